iv_port_responder: RTL and testbench

IV_PORT_RESPONDER -- requirements
Module: iv_port_responder

---
 rtl/iv_port_responder.sv | 96 +++++++++
 tb/tb_iv_port_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iv_port_responder.sv
// IV bus port responder: 3 write registers (R0..R2) and one input port (R3) at a 4-aligned base.
// Optional macro IV_RESP_READBACK_EN makes R0..R2 readable; otherwise they read as 8'h00.
module iv_port_responder #(
    parameter int unsigned BANK      = 0,
    parameter logic [7:0]  BASE_ADDR = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mclk,
    input  logic        sc,
    input  logic        wc,
    input  logic        lb,
    input  logic        rb,
    input  logic [7:0]  iv_in,
    output logic [7:0]  iv_out,
    output logic        iv_oe,
    output logic [23:0] port_out,
    output logic [2:0]  wr_stb,
    input  logic [7:0]  port_in,
    output logic        rd_ack
);

    logic [20:0] sync1;
    logic [20:0] sync2;
    logic        mclk_s, sc_s, wc_s, lb_s, rb_s;
    logic [7:0]  iv_s, pin_s;
    logic        mclk_d;
    logic        bs;
    logic        fall;
    logic [7:0]  data;
    logic [1:0]  addr;
    logic        selected;
    logic        oe_next;
    logic [7:0]  rdata;

    assign {mclk_s, sc_s, wc_s, lb_s, rb_s, iv_s, pin_s} = sync2;

    assign bs      = (BANK == 0) ? lb_s : rb_s;
    // mclk_d resets to 0, so no edge is seen until synchronized mclk has been 1
    assign fall    = mclk_d & ~mclk_s;
    assign data    = ~iv_s;
    assign oe_next = selected & bs & ~sc_s & ~wc_s;

    always_comb begin
        rdata = '0;
        case (addr)
            2'd3: rdata = pin_s;
`ifdef IV_RESP_READBACK_EN
            2'd0: rdata = port_out[7:0];
            2'd1: rdata = port_out[15:8];
            2'd2: rdata = port_out[23:16];
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            mclk_d   <= 1'b0;
            addr     <= '0;
            selected <= 1'b0;
            port_out <= '0;
            wr_stb   <= '0;
            iv_oe    <= 1'b0;
            iv_out   <= '1;
            rd_ack   <= 1'b0;
        end else begin
            sync1  <= {mclk, sc, wc, lb, rb, iv_in, port_in};
            sync2  <= sync1;
            mclk_d <= mclk_s;
            wr_stb <= '0;

            if (fall && bs) begin
                if (sc_s) begin
                    addr     <= data[1:0];
                    selected <= (data[7:2] == BASE_ADDR[7:2]);
                end else if (wc_s && selected) begin
                    case (addr)
                        2'd0: begin port_out[7:0]   <= data; wr_stb[0] <= 1'b1; end
                        2'd1: begin port_out[15:8]  <= data; wr_stb[1] <= 1'b1; end
                        2'd2: begin port_out[23:16] <= data; wr_stb[2] <= 1'b1; end
                        default: ;
                    endcase
                end
            end

            iv_oe  <= oe_next;
            iv_out <= oe_next ? ~rdata : 8'hFF;
            // addr cannot change while oe_next is high (that needs sc=1), so this fires once per read
            rd_ack <= oe_next & ~iv_oe & (addr == 2'd3);
        end
    end

endmodule

// File: tb/tb_iv_port_responder.sv
// Directed self-checking bench for iv_port_responder (BANK=0, BASE_ADDR=8'h40).
// Readback expectations follow IV_RESP_READBACK_EN as defined for the build.
module tb_iv_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mclk, sc, wc, lb, rb;
    logic [7:0]  iv_in, port_in;
    logic [7:0]  iv_out;
    logic        iv_oe;
    logic [23:0] port_out;
    logic [2:0]  wr_stb;
    logic        rd_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int stb_cnt;
    logic [2:0] stb_val;
    int acks;

`ifdef IV_RESP_READBACK_EN
    localparam logic [7:0] RB_R0 = 8'h88;
    localparam logic [7:0] RB_R1 = 8'h5A;
`else
    localparam logic [7:0] RB_R0 = 8'hFF;
    localparam logic [7:0] RB_R1 = 8'hFF;
`endif

    iv_port_responder #(.BANK(0), .BASE_ADDR(8'h40)) dut (
        .clk(clk), .rst(rst), .mclk(mclk), .sc(sc), .wc(wc), .lb(lb), .rb(rb),
        .iv_in(iv_in), .iv_out(iv_out), .iv_oe(iv_oe), .port_out(port_out),
        .wr_stb(wr_stb), .port_in(port_in), .rd_ack(rd_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One bus cycle: set up with mclk high, drop mclk, count wr_stb pulses, release.
    task automatic bus(input logic s, input logic w, input logic l, input logic r,
                       input logic [7:0] d, output int cnt, output logic [2:0] val);
        mclk = 1'b1; sc = s; wc = w; lb = l; rb = r; iv_in = ~d;
        repeat (4) @(negedge clk);
        mclk = 1'b0; cnt = 0; val = '0;
        repeat (6) begin
            @(negedge clk);
            if (wr_stb != 3'b000) begin cnt++; val = wr_stb; end
        end
        sc = 1'b0; wc = 1'b0; lb = 1'b0; rb = 1'b0; iv_in = 8'hFF;
        repeat (3) @(negedge clk);
    endtask

    task automatic read_hold(output int a);
        sc = 1'b0; wc = 1'b0; lb = 1'b1; a = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_ack) a++;
        end
    endtask

    task automatic read_release();
        lb = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mclk = 1'b0; sc = 1'b0; wc = 1'b0; lb = 1'b0; rb = 1'b0;
        iv_in = 8'hFF; port_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_iv_out", 32'(iv_out), 32'hFF);
        check("rst_iv_oe", 32'(iv_oe), 32'h0);
        check("rst_port_out", 32'(port_out), 32'h0);
        check("rst_wr_stb", 32'(wr_stb), 32'h0);
        check("rst_rd_ack", 32'(rd_ack), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // select R1 and write A5
        bus(1, 0, 1, 0, 8'h41, stb_cnt, stb_val);
        check("sel_no_stb", 32'(stb_cnt), 0);
        bus(0, 1, 1, 0, 8'hA5, stb_cnt, stb_val);
        check("wr1_port_out", 32'(port_out), 32'h00A500);
        check("wr1_stb_cnt", 32'(stb_cnt), 1);
        check("wr1_stb_val", 32'(stb_val), 32'h2);

        // foreign address deselects
        bus(1, 0, 1, 0, 8'h81, stb_cnt, stb_val);
        bus(0, 1, 1, 0, 8'h3C, stb_cnt, stb_val);
        check("foreign_port_out", 32'(port_out), 32'h00A500);
        check("foreign_stb_cnt", 32'(stb_cnt), 0);
        read_hold(acks);
        check("foreign_iv_oe", 32'(iv_oe), 0);
        check("foreign_iv_out", 32'(iv_out), 32'hFF);
        read_release();

        // input port read
        bus(1, 0, 1, 0, 8'h43, stb_cnt, stb_val);
        port_in = 8'h5A;
        read_hold(acks);
        check("in_iv_oe", 32'(iv_oe), 1);
        check("in_iv_out", 32'(iv_out), 32'hA5);
        port_in = 8'h0F;
        repeat (4) begin
            @(negedge clk);
            if (rd_ack) acks++;
        end
        check("in_resample", 32'(iv_out), 32'hF0);
        check("in_rd_ack_cnt", 32'(acks), 1);
        read_release();
        check("in_end_iv_oe", 32'(iv_oe), 0);
        check("in_end_iv_out", 32'(iv_out), 32'hFF);

        // write to R3 has no effect
        bus(0, 1, 1, 0, 8'hEE, stb_cnt, stb_val);
        check("r3wr_port_out", 32'(port_out), 32'h00A500);
        check("r3wr_stb_cnt", 32'(stb_cnt), 0);

        // R0 write and readback
        bus(1, 0, 1, 0, 8'h40, stb_cnt, stb_val);
        bus(0, 1, 1, 0, 8'h77, stb_cnt, stb_val);
        check("wr0_port_out", 32'(port_out), 32'h00A577);
        check("wr0_stb_cnt", 32'(stb_cnt), 1);
        check("wr0_stb_val", 32'(stb_val), 32'h1);
        read_hold(acks);
        check("rb0_iv_oe", 32'(iv_oe), 1);
        check("rb0_iv_out", 32'(iv_out), 32'(RB_R0));
        check("rb0_no_ack", 32'(acks), 0);
        read_release();

        // sc+wc together: select wins, nothing written
        bus(1, 1, 1, 0, 8'h41, stb_cnt, stb_val);
        check("prio_stb_cnt", 32'(stb_cnt), 0);
        check("prio_port_out", 32'(port_out), 32'h00A577);
        read_hold(acks);
        check("prio_iv_oe", 32'(iv_oe), 1);
        check("prio_iv_out", 32'(iv_out), 32'(RB_R1));
        read_release();

        // right bank ignored with BANK=0
        bus(1, 0, 0, 1, 8'h81, stb_cnt, stb_val);
        bus(0, 1, 0, 1, 8'h11, stb_cnt, stb_val);
        check("rb_stb_cnt", 32'(stb_cnt), 0);
        check("rb_port_out", 32'(port_out), 32'h00A577);
        read_hold(acks);
        check("rb_still_sel", 32'(iv_oe), 1);
        check("rb_iv_out", 32'(iv_out), 32'(RB_R1));
        read_release();

        // reset between write setup and mclk fall
        bus(1, 0, 1, 0, 8'h42, stb_cnt, stb_val);
        mclk = 1'b1; sc = 1'b0; wc = 1'b1; lb = 1'b1; iv_in = ~8'h99;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_iv_oe", 32'(iv_oe), 0);
        check("midrst_iv_out", 32'(iv_out), 32'hFF);
        check("midrst_port_out", 32'(port_out), 32'h0);
        rst = 1'b0; mclk = 1'b0; stb_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr_stb != 3'b000) stb_cnt++;
        end
        check("midrst_stb_cnt", 32'(stb_cnt), 0);
        check("midrst_r2", 32'(port_out[23:16]), 32'h0);
        check("midrst_oe_after", 32'(iv_oe), 0);
        wc = 1'b0; lb = 1'b0; iv_in = 8'hFF;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
